bb_ext_arbiter: RTL and testbench

Round-robin arbiter sharing the single external blackbone memory port (bb_ext_addr/din/en/we/dout) of the mpsoc4d_msp430 system among NUM_REQ requesters, e.g. per-tile bridges or the debug DMA path. It issues registered single-cycle transactions on the shared port. It then routes read data back to the issuing requester after a fixed memory latency, using an ID pipeline. It sits between the tile-side requesters and the external memory model or controller.

---
 rtl/bb_ext_arbiter.sv | 162 ++++++++++++++++
 tb/tb_bb_ext_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bb_ext_arbiter.sv
// Round-robin arbiter for the shared external blackbone memory port.
// Grants are registered single-cycle transactions. Read data is steered back to
// the issuing requester through a fixed-latency ID pipeline.
// Optional build macro BB_ARB_STATS_EN adds per-requester saturating grant counters
// (grant_cnt_o) with a synchronous clear (stats_clr_i).
module bb_ext_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_en_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_din_i,
  output logic [NUM_REQ-1:0]        req_gnt_o,
  output logic [NUM_REQ-1:0]        req_rvalid_o,
  output logic [DATA_W-1:0]         req_dout_o,
  output logic [ADDR_W-1:0]         bb_addr_o,
  output logic [DATA_W-1:0]         bb_din_o,
  output logic                      bb_en_o,
  output logic                      bb_we_o,
  input  logic [DATA_W-1:0]         bb_dout_i,
`ifdef BB_ARB_STATS_EN
  input  logic                      stats_clr_i,
  output logic [NUM_REQ*16-1:0]     grant_cnt_o,
`endif
  output logic                      busy_o
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]              gnt_q, gnt_d;
  logic [NUM_REQ-1:0]              eligible;
  logic [IdW-1:0]                  rr_q, rr_d;
  logic [IdW-1:0]                  win_idx, id_q;
  logic                            win_found;
  logic [IdW:0]                    sum;
  logic [IdW:0]                    rr_inc;
  logic                            en_q, we_q;
  logic [ADDR_W-1:0]               addr_q;
  logic [DATA_W-1:0]               din_q;
  logic [MEM_LAT-1:0]              pipe_vld_q;
  logic [MEM_LAT-1:0][IdW-1:0]     pipe_id_q;
  logic [NUM_REQ-1:0]              rvalid_q, rvalid_d;
  logic [DATA_W-1:0]               dout_q;

  // The requester seeing its grant this cycle still holds en, so it is masked.
  assign eligible = req_en_i & ~gnt_q;

  // Winner search: first eligible index at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_q} + (IdW+1)'(k);
      if (sum >= (IdW+1)'(NUM_REQ)) sum = sum - (IdW+1)'(NUM_REQ);
      if (!win_found && eligible[sum[IdW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[IdW-1:0];
      end
    end
  end

  // Grant vector and next round-robin pointer.
  always_comb begin
    gnt_d  = '0;
    rr_d   = rr_q;
    rr_inc = {1'b0, win_idx} + (IdW+1)'(1);
    if (win_found) begin
      gnt_d[win_idx] = 1'b1;
      rr_d = (rr_inc == (IdW+1)'(NUM_REQ)) ? '0 : rr_inc[IdW-1:0];
    end
  end

  // Shared-port transaction register; payload holds when nobody wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      rr_q   <= '0;
      id_q   <= '0;
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      gnt_q <= gnt_d;
      rr_q  <= rr_d;
      en_q  <= win_found;
      if (win_found) begin
        id_q   <= win_idx;
        we_q   <= req_we_i[win_idx];
        addr_q <= req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
        din_q  <= req_din_i[int'(win_idx)*DATA_W +: DATA_W];
      end
    end
  end

  // Read ID pipeline: stage 0 loads while bb_en_o is high, the last stage lines
  // up with the cycle in which bb_dout_i is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      pipe_vld_q[0] <= en_q & ~we_q;
      pipe_id_q[0]  <= id_q;
      for (int k = 1; k < MEM_LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_id_q[k]  <= pipe_id_q[k-1];
      end
    end
  end

  // Decode the exiting ID into a one-hot rvalid.
  always_comb begin
    rvalid_d = '0;
    if (pipe_vld_q[MEM_LAT-1]) rvalid_d[pipe_id_q[MEM_LAT-1]] = 1'b1;
  end

  // Register the return strobe and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      dout_q   <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      if (pipe_vld_q[MEM_LAT-1]) dout_q <= bb_dout_i;
    end
  end

`ifdef BB_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q;

  // Saturating per-requester grant counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr_i) cnt_q[i] <= '0;
        else if (gnt_d[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

  assign req_gnt_o    = gnt_q;
  assign req_rvalid_o = rvalid_q;
  assign req_dout_o   = dout_q;
  assign bb_addr_o    = addr_q;
  assign bb_din_o     = din_q;
  assign bb_en_o      = en_q;
  assign bb_we_o      = we_q;
  assign busy_o       = (|gnt_q) | (|pipe_vld_q);

endmodule

// File: tb/tb_bb_ext_arbiter.sv
// Directed self-checking bench for bb_ext_arbiter (NUM_REQ=4, MEM_LAT=2).
module tb_bb_ext_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_en_i = '0;
  logic [3:0]   req_we_i = '0;
  logic [127:0] req_addr_i = '0;
  logic [127:0] req_din_i = '0;
  logic [3:0]   req_gnt_o;
  logic [3:0]   req_rvalid_o;
  logic [31:0]  req_dout_o;
  logic [31:0]  bb_addr_o;
  logic [31:0]  bb_din_o;
  logic         bb_en_o;
  logic         bb_we_o;
  logic [31:0]  bb_dout_i;
  logic         busy_o;
`ifdef BB_ARB_STATS_EN
  logic         stats_clr_i = 1'b0;
  logic [63:0]  grant_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bb_ext_arbiter #(
    .NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_en_i     (req_en_i),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_din_i    (req_din_i),
    .req_gnt_o    (req_gnt_o),
    .req_rvalid_o (req_rvalid_o),
    .req_dout_o   (req_dout_o),
    .bb_addr_o    (bb_addr_o),
    .bb_din_o     (bb_din_o),
    .bb_en_o      (bb_en_o),
    .bb_we_o      (bb_we_o),
    .bb_dout_i    (bb_dout_i),
`ifdef BB_ARB_STATS_EN
    .stats_clr_i  (stats_clr_i),
    .grant_cnt_o  (grant_cnt_o),
`endif
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Memory model: data for the address presented two cycles earlier.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0000_CAFE;
      32'h0000_0010: return 32'h1111_0010;
      32'h0000_0020: return 32'h2222_0020;
      default:       return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  logic [31:0] a1 = '0;
  logic [31:0] a2 = '0;
  always @(posedge clk) begin
    a1 <= bb_addr_o;
    a2 <= a1;
  end
  assign bb_dout_i = mem_data(a2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_en_i   = '0;
    req_we_i   = '0;
    req_addr_i = '0;
    req_din_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (req_gnt_o !== 4'b0 || bb_en_o !== 1'b0 || bb_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt=%b en=%b we=%b, required 0000/0/0",
               req_gnt_o, bb_en_o, bb_we_o);
    end
    n_checks++;
    if (bb_addr_o !== 32'h0 || bb_din_o !== 32'h0 || req_dout_o !== 32'h0 ||
        req_rvalid_o !== 4'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h din=%h dout=%h rvalid=%b busy=%b, required all 0",
               bb_addr_o, bb_din_o, req_dout_o, req_rvalid_o, busy_o);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req_en_i = 4'b0010;
    req_we_i = 4'b0000;
    req_addr_i[32 +: 32] = 32'h100;
    tick();
    n_checks++;
    if (req_gnt_o !== 4'b0010 || bb_en_o !== 1'b1 || bb_we_o !== 1'b0 ||
        bb_addr_o !== 32'h100) begin
      n_fail++;
      $display("FAIL sread_grant: gnt=%b en=%b we=%b addr=%h, required 0010/1/0/00000100",
               req_gnt_o, bb_en_o, bb_we_o, bb_addr_o);
    end
    req_en_i = 4'b0000;
    tick();
    n_checks++;
    if (req_gnt_o !== 4'b0 || bb_en_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sread_idle: gnt=%b en=%b busy=%b, required 0000/0/1",
               req_gnt_o, bb_en_o, busy_o);
    end
    tick();
    n_checks++;
    if (req_rvalid_o !== 4'b0) begin
      n_fail++;
      $display("FAIL sread_early: rvalid=%b, required 0000", req_rvalid_o);
    end
    tick();
    n_checks++;
    if (req_rvalid_o !== 4'b0010 || req_dout_o !== 32'h0000_CAFE) begin
      n_fail++;
      $display("FAIL sread_return: rvalid=%b dout=%h, required 0010/0000cafe",
               req_rvalid_o, req_dout_o);
    end
    tick();
    n_checks++;
    if (req_rvalid_o !== 4'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sread_after: rvalid=%b busy=%b, required 0000/0", req_rvalid_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_gnt;
    logic [31:0] exp_addr;
    logic [31:0] exp_din;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_addr_i[i*32 +: 32] = 32'h4000 + 32'(i) * 32'h10;
      req_din_i[i*32 +: 32]  = 32'hD000_0000 + 32'(i);
    end
    req_we_i = 4'b1111;
    req_en_i = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      tick();
      exp_gnt  = 4'b0001 << (c % 4);
      exp_addr = 32'h4000 + 32'(c % 4) * 32'h10;
      exp_din  = 32'hD000_0000 + 32'(c % 4);
      n_checks++;
      if (req_gnt_o !== exp_gnt || bb_en_o !== 1'b1 || bb_we_o !== 1'b1 ||
          bb_addr_o !== exp_addr || bb_din_o !== exp_din || req_rvalid_o !== 4'b0) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: gnt=%b en=%b we=%b addr=%h din=%h rv=%b, required %b/1/1/%h/%h/0000",
                 c, req_gnt_o, bb_en_o, bb_we_o, bb_addr_o, bb_din_o, req_rvalid_o,
                 exp_gnt, exp_addr, exp_din);
      end
    end
    req_en_i = 4'b0000;
    repeat (4) tick();
    n_checks++;
    if (req_rvalid_o !== 4'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_norvalid: rvalid=%b busy=%b, required 0000/0", req_rvalid_o, busy_o);
    end
  endtask

  task automatic test_single_hold();
    logic [5:0] exp_en;
    int         grants;
    exp_en = 6'b010101;
    grants = 0;
    do_reset();
    req_we_i = 4'b0100;
    req_addr_i[64 +: 32] = 32'h200;
    req_en_i = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (req_gnt_o == 4'b0100) grants++;
      n_checks++;
      if (bb_en_o !== exp_en[c]) begin
        n_fail++;
        $display("FAIL hold_en_cycle%0d: bb_en=%b, required %b", c, bb_en_o, exp_en[c]);
      end
    end
    req_en_i = 4'b0000;
    n_checks++;
    if (grants != 3) begin
      n_fail++;
      $display("FAIL hold_grants: count=%0d, required 3", grants);
    end
  endtask

  task automatic test_mixed_read();
    do_reset();
    req_we_i = 4'b0000;
    req_addr_i[0 +: 32]  = 32'h10;
    req_addr_i[96 +: 32] = 32'h20;
    req_en_i = 4'b1001;
    tick();
    n_checks++;
    if (req_gnt_o !== 4'b0001 || bb_addr_o !== 32'h10) begin
      n_fail++;
      $display("FAIL mixed_first: gnt=%b addr=%h, required 0001/00000010", req_gnt_o, bb_addr_o);
    end
    req_en_i = 4'b1000;
    tick();
    n_checks++;
    if (req_gnt_o !== 4'b1000 || bb_addr_o !== 32'h20 || bb_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mixed_second: gnt=%b addr=%h en=%b, required 1000/00000020/1",
               req_gnt_o, bb_addr_o, bb_en_o);
    end
    req_en_i = 4'b0000;
    tick();
    n_checks++;
    if (req_rvalid_o !== 4'b0) begin
      n_fail++;
      $display("FAIL mixed_early: rvalid=%b, required 0000", req_rvalid_o);
    end
    tick();
    n_checks++;
    if (req_rvalid_o !== 4'b0001 || req_dout_o !== 32'h1111_0010) begin
      n_fail++;
      $display("FAIL mixed_ret0: rvalid=%b dout=%h, required 0001/11110010",
               req_rvalid_o, req_dout_o);
    end
    tick();
    n_checks++;
    if (req_rvalid_o !== 4'b1000 || req_dout_o !== 32'h2222_0020) begin
      n_fail++;
      $display("FAIL mixed_ret3: rvalid=%b dout=%h, required 1000/22220020",
               req_rvalid_o, req_dout_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_we_i = 4'b0000;
    req_addr_i[0 +: 32]  = 32'h300;
    req_addr_i[32 +: 32] = 32'h304;
    req_en_i = 4'b0011;
    tick();
    req_en_i = 4'b0010;
    tick();
    n_checks++;
    if (req_gnt_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL rmid_pre: gnt=%b, required 0010", req_gnt_o);
    end
    req_en_i = 4'b0000;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_gnt_o !== 4'b0 || bb_en_o !== 1'b0 || bb_addr_o !== 32'h0 ||
        bb_din_o !== 32'h0 || bb_we_o !== 1'b0 || req_rvalid_o !== 4'b0 ||
        req_dout_o !== 32'h0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: gnt=%b en=%b addr=%h din=%h we=%b rv=%b dout=%h busy=%b, required all 0",
               req_gnt_o, bb_en_o, bb_addr_o, bb_din_o, bb_we_o, req_rvalid_o,
               req_dout_o, busy_o);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (req_rvalid_o !== 4'b0) begin
        n_fail++;
        $display("FAIL rmid_dropped_cycle%0d: rvalid=%b, required 0000", c, req_rvalid_o);
      end
    end
    req_we_i = 4'b0111;
    req_en_i = 4'b0111;
    tick();
    req_en_i = 4'b0000;
    n_checks++;
    if (req_gnt_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL rmid_rr_restart: gnt=%b, required 0001", req_gnt_o);
    end
    tick();
  endtask

`ifdef BB_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req_we_i = 4'b0010;
    req_en_i = 4'b0010;
    repeat (600) tick();
    req_en_i = 4'b0000;
    tick();
    n_checks++;
    if (grant_cnt_o[31:16] !== 16'd300) begin
      n_fail++;
      $display("FAIL stats_count: cnt1=%0d, required 300", grant_cnt_o[31:16]);
    end
    stats_clr_i = 1'b1;
    tick();
    stats_clr_i = 1'b0;
    n_checks++;
    if (grant_cnt_o !== 64'h0) begin
      n_fail++;
      $display("FAIL stats_clear: cnt=%h, required 0", grant_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_single_hold();
    test_mixed_read();
    test_reset_mid();
`ifdef BB_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
